operand_streamer: RTL and testbench

Operand source for the convolution datapath: walks the same x / y / ch_in / ch_out / k_v loop nest as the datapath controller. For each MAC it reads one feature-map element (A) and one kernel weight (B) from a 1-cycle-latency memory. It presents them on the controller's a/b valid/ready ports, A first then B, so it is the transmitting end of the controller's operand handshake.

---
 rtl/operand_streamer.sv | 187 ++++++++++++++++++
 tb/tb_operand_streamer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_streamer.sv
// rtl/operand_streamer.sv - feature/weight operand source for the convolution datapath
// Optional ZERO_PAD_EN: out-of-map rows are not read and yield zero A operands.
module operand_streamer #(
    parameter int DATA_WIDTH         = 16,
    parameter int ADDR_WIDTH         = 20,
    parameter int FEATURE_MAP_WIDTH  = 128,
    parameter int FEATURE_MAP_HEIGHT = 128,
    parameter int INPUT_NB_CHANNELS  = 2,
    parameter int OUTPUT_NB_CHANNELS = 16,
    parameter int KERNEL_SIZE        = 3,
    parameter int KERNEL_BASE        = 2**19
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  start,
    input  logic [1:0]            conv_stride_mode,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  a_valid,
    input  logic                  a_ready,
    output logic [DATA_WIDTH-1:0] a_data,
    output logic                  b_valid,
    input  logic                  b_ready,
    output logic [DATA_WIDTH-1:0] b_data
);
    localparam int W    = FEATURE_MAP_WIDTH;
    localparam int H    = FEATURE_MAP_HEIGHT;
    localparam int K    = KERNEL_SIZE;
    localparam int XW   = $clog2(W) + 2;
    localparam int YW   = $clog2(H) + 2;
    localparam int RW   = YW + 1;
    localparam int CIW  = $clog2(INPUT_NB_CHANNELS + 1);
    localparam int COW  = $clog2(OUTPUT_NB_CHANNELS + 1);
    localparam int KW   = $clog2(K + 1);
    localparam int PADT = (K - 1) / 2;
    localparam int AW   = ADDR_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_RD_A, S_SEND_A, S_RD_B, S_SEND_B, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [CIW-1:0]  ci_q;
    logic [COW-1:0]  co_q;
    logic [KW-1:0]   kv_q;
    logic [1:0]      shift_q;
    logic            fresh_q;
    logic            pad_q;
    logic [DATA_WIDTH-1:0] a_hold_q, b_hold_q;

    logic [2:0]           stride_v;
    logic                 last_x, last_y, last_ci, last_co, last_kv, last_all;
    logic signed [RW-1:0] row;
    logic [RW-1:0]        row_u;
    logic                 row_out;
    logic                 skip_a;
    logic [AW-1:0]        addr_a, addr_b;
    logic                 adv;

    always_comb begin
        stride_v = 3'd1 << shift_q;
        last_x   = (32'(x_q) + 32'(stride_v)) >= 32'(W);
        last_y   = (32'(y_q) + 32'(stride_v)) >= 32'(H);
        last_ci  = ci_q == CIW'(INPUT_NB_CHANNELS - 1);
        last_co  = co_q == COW'(OUTPUT_NB_CHANNELS - 1);
        last_kv  = kv_q == KW'(K - 1);
        last_all = last_x && last_y && last_ci && last_co && last_kv;

        row     = $signed({1'b0, y_q}) + $signed(RW'(kv_q)) - $signed(RW'(PADT));
        row_out = (row < 0) || (row >= $signed(RW'(H)));
        // Clamped row doubles as edge replication when padding is not compiled in.
        if (row < 0)
            row_u = '0;
        else if (row >= $signed(RW'(H)))
            row_u = RW'(H - 1);
        else
            row_u = $unsigned(row);
`ifdef ZERO_PAD_EN
        skip_a = row_out;
`else
        skip_a = 1'b0;
`endif
        addr_a = (AW'(ci_q) * AW'(H) + AW'(row_u)) * AW'(W) + AW'(x_q);
        addr_b = AW'(KERNEL_BASE)
               + (AW'(co_q) * AW'(INPUT_NB_CHANNELS) + AW'(ci_q)) * AW'(K) + AW'(kv_q);
    end

    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        mem_re   = 1'b0;
        mem_addr = '0;
        a_valid  = 1'b0;
        b_valid  = 1'b0;
        adv      = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_RD_A;
            S_RD_A: begin
                busy     = 1'b1;
                mem_re   = !skip_a;
                mem_addr = addr_a;
                state_d  = S_SEND_A;
            end
            S_SEND_A: begin
                busy    = 1'b1;
                a_valid = 1'b1;
                if (a_ready) state_d = S_RD_B;
            end
            S_RD_B: begin
                busy     = 1'b1;
                mem_re   = 1'b1;
                mem_addr = addr_b;
                state_d  = S_SEND_B;
            end
            S_SEND_B: begin
                busy    = 1'b1;
                b_valid = 1'b1;
                if (b_ready) begin
                    adv     = 1'b1;
                    state_d = last_all ? S_DONE : S_RD_A;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read data lands in the first SEND cycle; it is held from then on so the
    // operand stays stable under backpressure whatever the memory does next.
    always_comb begin
        a_data = a_hold_q;
        b_data = b_hold_q;
        if (state_q == S_SEND_A && fresh_q) a_data = pad_q ? '0 : mem_rdata;
        if (state_q == S_SEND_B && fresh_q) b_data = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            ci_q     <= '0;
            co_q     <= '0;
            kv_q     <= '0;
            shift_q  <= '0;
            fresh_q  <= 1'b0;
            pad_q    <= 1'b0;
            a_hold_q <= '0;
            b_hold_q <= '0;
        end else begin
            state_q <= state_d;
            fresh_q <= (state_q == S_RD_A) || (state_q == S_RD_B);
            if (state_q == S_RD_A) pad_q <= skip_a;
            if (state_q == S_SEND_A && fresh_q) a_hold_q <= a_data;
            if (state_q == S_SEND_B && fresh_q) b_hold_q <= b_data;
            if (state_q == S_IDLE && start)
                shift_q <= (conv_stride_mode == 2'd0) ? 2'd0 :
                           (conv_stride_mode == 2'd1) ? 2'd1 : 2'd2;
            if (adv) begin
                if (!last_kv) kv_q <= kv_q + KW'(1);
                else begin
                    kv_q <= '0;
                    if (!last_co) co_q <= co_q + COW'(1);
                    else begin
                        co_q <= '0;
                        if (!last_ci) ci_q <= ci_q + CIW'(1);
                        else begin
                            ci_q <= '0;
                            if (!last_y) y_q <= y_q + YW'(stride_v);
                            else begin
                                y_q <= '0;
                                x_q <= last_x ? '0 : x_q + XW'(stride_v);
                            end
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_operand_streamer.sv
// tb/tb_operand_streamer.sv - self-checking bench for operand_streamer on a 4x4x2x2x3 configuration
module tb_operand_streamer;
    localparam int DW = 16, AWD = 20, W = 4, H = 4, CI = 2, CO = 2, K = 3;
    localparam int KB = 2**19;

    logic           clk = 1'b0;
    logic           rst_in, start, a_ready, b_ready;
    logic [1:0]     conv_stride_mode;
    logic           busy, done, mem_re, a_valid, b_valid;
    logic [AWD-1:0] mem_addr;
    logic [DW-1:0]  mem_rdata = '0;
    logic [DW-1:0]  a_data, b_data;

    operand_streamer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
        .INPUT_NB_CHANNELS(CI), .OUTPUT_NB_CHANNELS(CO), .KERNEL_SIZE(K), .KERNEL_BASE(KB)
    ) dut (
        .clk(clk), .rst_in(rst_in), .start(start), .conv_stride_mode(conv_stride_mode),
        .busy(busy), .done(done), .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_word(input logic [AWD-1:0] a);
        logic [DW-1:0] lo;
        lo = a[DW-1:0];
        return (lo * 16'd37) ^ {a[19:16], 12'h5A3};
    endfunction

    always @(posedge clk) if (mem_re) mem_rdata <= mem_word(mem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    logic [AWD-1:0] exp_rd[$];
    logic [DW-1:0]  exp_a[$], exp_b[$];

    // Reference: walk the loop nest directly and list every read and operand in order.
    task automatic build_model(input int mode);
        int s, row, rc;
        logic [AWD-1:0] aa, ba;
        exp_rd.delete(); exp_a.delete(); exp_b.delete();
        s = (mode == 0) ? 1 : (mode == 1) ? 2 : 4;
        for (int x = 0; x < W; x += s)
            for (int y = 0; y < H; y += s)
                for (int ci = 0; ci < CI; ci++)
                    for (int co = 0; co < CO; co++)
                        for (int kv = 0; kv < K; kv++) begin
                            row = y + kv - (K - 1) / 2;
                            rc  = (row < 0) ? 0 : (row >= H) ? H - 1 : row;
                            aa  = AWD'((ci * H + rc) * W + x);
                            ba  = AWD'(KB + (co * CI + ci) * K + kv);
`ifdef ZERO_PAD_EN
                            if (row < 0 || row >= H) exp_a.push_back('0);
                            else begin
                                exp_rd.push_back(aa);
                                exp_a.push_back(mem_word(aa));
                            end
`else
                            exp_rd.push_back(aa);
                            exp_a.push_back(mem_word(aa));
`endif
                            exp_rd.push_back(ba);
                            exp_b.push_back(mem_word(ba));
                        end
    endtask

    bit chk_en = 0, done_seen = 0;
    int t0 = 0, hs_cnt = 0, a_hs = 0, done_rel = 0;
    logic [AWD-1:0] last_a_addr = '0;

    always begin
        int rel;
        logic [AWD-1:0] e;
        @(negedge clk);
        #1;
        if (chk_en) begin
            rel = cyc - t0;
            chk("a_b_exclusive", {31'd0, a_valid && b_valid}, 32'd0);
            if (mem_re) begin
                if (exp_rd.size() == 0) chk("extra_read", mem_addr, 32'hFFFFFFFF);
                else begin
                    e = exp_rd.pop_front();
                    chk("mem_addr", mem_addr, e);
                end
                if (mem_addr < AWD'(KB)) last_a_addr = mem_addr;
            end
            if (a_valid && a_ready) begin
                a_hs++;
                if (exp_a.size() == 0) chk("extra_a", a_data, 32'hFFFFFFFF);
                else chk("a_data", a_data, exp_a.pop_front());
            end
            if (b_valid && b_ready) begin
                hs_cnt++;
                if (exp_b.size() == 0) chk("extra_b", b_data, 32'hFFFFFFFF);
                else chk("b_data", b_data, exp_b.pop_front());
            end
            if (done && !done_seen) begin
                done_seen = 1;
                done_rel  = rel;
                chk("busy_at_done", busy, 0);
            end
            if (rel == 0) chk("busy_before_start", busy, 0);
            if (rel == 1) begin
                chk("busy_rd_a", busy, 1);
`ifdef ZERO_PAD_EN
                chk("first_a_no_read", mem_re, 0);
`else
                chk("first_a_read", mem_re, 1);
                chk("first_a_addr_clamped", mem_addr, 0);
`endif
            end
            if (rel == 2) begin
                chk("first_a_valid", a_valid, 1);
`ifdef ZERO_PAD_EN
                chk("first_a_zero", a_data, 0);
`else
                chk("first_a_word0", a_data, mem_word('0));
`endif
            end
            if (rel == 3) begin
                chk("first_b_read", mem_re, 1);
                chk("first_b_addr", mem_addr, KB);
            end
        end
    end

    task automatic begin_pass(input int mode);
        build_model(mode);
        hs_cnt = 0; a_hs = 0; done_seen = 0;
        @(negedge clk);
        start = 1; conv_stride_mode = 2'(mode); t0 = cyc; chk_en = 1;
    endtask

    task automatic run_pass(input int mode, input bit do_stall, input bit poke,
                            input int exp_hs, input int exp_done);
        bit stalled;
        logic [DW-1:0] held;
        stalled = 0;
        begin_pass(mode);
        chk("model_len", exp_b.size(), exp_hs);
        for (int i = 0; i < 4000 && !done_seen; i++) begin
            @(negedge clk);
            start = poke && (cyc - t0 == 100);
            if (do_stall && !stalled && a_valid && a_hs == 3) begin
                stalled = 1;
                held    = a_data;
                a_ready = 0;
                for (int j = 0; j < 5; j++) begin
                    #1;
                    chk("stall_a_valid", a_valid, 1);
                    chk("stall_a_data", a_data, held);
                    chk("stall_no_re", mem_re, 0);
                    chk("stall_b_valid", b_valid, 0);
                    @(negedge clk);
                end
                a_ready = 1;
            end
        end
        start = 0;
        chk("done_seen", done_seen, 1);
        chk_en = 0;
        chk("hs_count", hs_cnt, exp_hs);
        chk("done_cycle", done_rel, exp_done);
        chk("model_drained", exp_rd.size() + exp_a.size() + exp_b.size(), 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_outs"}, {busy, done, mem_re, a_valid, b_valid}, 0);
        chk({nm, "_addr"}, mem_addr, 0);
        chk({nm, "_a_data"}, a_data, 0);
        chk({nm, "_b_data"}, b_data, 0);
    endtask

    initial begin
        rst_in = 1; start = 0; a_ready = 1; b_ready = 1; conv_stride_mode = 2'd0;
        repeat (3) @(negedge clk);
        #1 chk_zero("reset");
        @(negedge clk);
        rst_in = 0;

        run_pass(0, 0, 0, 192, 769);
        run_pass(1, 0, 0, 48, 193);
        chk("last_a_addr_s2", last_a_addr, 30);
        run_pass(3, 0, 0, 12, 49);
        run_pass(0, 1, 0, 192, 774);
        run_pass(0, 0, 1, 192, 769);

        begin_pass(0);
        for (int i = 0; i < 400 && !(hs_cnt >= 10 && b_valid); i++) begin
            @(negedge clk);
            start = 0;
        end
        chk("reached_send_b", b_valid, 1);
        rst_in = 1; chk_en = 0;
        @(negedge clk);
        #1 chk_zero("mid_reset");
        @(negedge clk);
        rst_in = 0;
        run_pass(0, 0, 0, 192, 769);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
